// File: rtl/seg7_scan_ctrl.sv
// Dynamic-scan controller for a 7-digit common-anode 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never blanked).
module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int DIGIT_NUM = 7
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [27:0] disp_data,
    input  logic [6:0]  dp_mask,
    input  logic [6:0]  digit_en,
    input  logic        disp_load,
    output logic [14:0] Data,
    output logic        S_EN
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] div_cnt;
    logic [2:0]       digit_idx;
    logic [2:0]       nxt_idx;
    logic             scan_tick;
    logic             frame_end;

    logic [27:0] pend_data, shad_data, shad_data_nxt;
    logic [6:0]  pend_dp, shad_dp, shad_dp_nxt;
    logic [6:0]  pend_en, shad_en, shad_en_nxt;
    logic        pending_valid;

    logic [3:0]  nib;
    logic [6:0]  seg_lo;
    logic [7:0]  seg;
    logic [6:0]  sel;

    assign scan_tick = (div_cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end = scan_tick && (digit_idx == 3'(DIGIT_NUM - 1));
    assign nxt_idx   = (digit_idx == 3'(DIGIT_NUM - 1)) ? 3'd0 : digit_idx + 3'd1;

    // Shadow only changes at a frame boundary; a load landing on that same tick bypasses pending.
    always_comb begin
        shad_data_nxt = shad_data;
        shad_dp_nxt   = shad_dp;
        shad_en_nxt   = shad_en;
        if (frame_end) begin
            if (disp_load) begin
                shad_data_nxt = disp_data;
                shad_dp_nxt   = dp_mask;
                shad_en_nxt   = digit_en;
            end else if (pending_valid) begin
                shad_data_nxt = pend_data;
                shad_dp_nxt   = pend_dp;
                shad_en_nxt   = pend_en;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] zero_from;

    // zero_from[i] is set when nibble i and every higher scanned nibble are zero.
    always_comb begin
        zero_from = '0;
        zero_from[DIGIT_NUM] = 1'b1;
        for (int i = DIGIT_NUM - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (shad_data_nxt[4*i +: 4] == 4'd0);
        end
    end
`endif

    always_comb begin
        nib = shad_data_nxt[{nxt_idx, 2'b00} +: 4];
        case (nib)
            4'h0: seg_lo = 7'h40;
            4'h1: seg_lo = 7'h79;
            4'h2: seg_lo = 7'h24;
            4'h3: seg_lo = 7'h30;
            4'h4: seg_lo = 7'h19;
            4'h5: seg_lo = 7'h12;
            4'h6: seg_lo = 7'h02;
            4'h7: seg_lo = 7'h78;
            4'h8: seg_lo = 7'h00;
            4'h9: seg_lo = 7'h10;
            4'hA: seg_lo = 7'h08;
            4'hB: seg_lo = 7'h03;
            4'hC: seg_lo = 7'h46;
            4'hD: seg_lo = 7'h21;
            4'hE: seg_lo = 7'h06;
            default: seg_lo = 7'h0E;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (nxt_idx != 3'd0 && zero_from[nxt_idx]) begin
            seg_lo = 7'h7F;
        end
`endif
        seg = {~shad_dp_nxt[nxt_idx], seg_lo};
        // A disabled digit still gets its select slot so scan duty stays uniform.
        if (!shad_en_nxt[nxt_idx]) begin
            seg = 8'hFF;
        end
        sel = 7'h7F;
        sel[nxt_idx] = 1'b0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            div_cnt       <= '0;
            digit_idx     <= 3'd0;
            Data          <= 15'h7FFF;
            S_EN          <= 1'b0;
            pend_data     <= '0;
            pend_dp       <= '0;
            pend_en       <= '0;
            shad_data     <= '0;
            shad_dp       <= '0;
            shad_en       <= '0;
            pending_valid <= 1'b0;
        end else begin
            div_cnt   <= scan_tick ? '0 : div_cnt + CNT_W'(1);
            S_EN      <= scan_tick;
            if (scan_tick) begin
                digit_idx <= nxt_idx;
                Data      <= {sel, seg};
            end
            shad_data <= shad_data_nxt;
            shad_dp   <= shad_dp_nxt;
            shad_en   <= shad_en_nxt;
            if (disp_load) begin
                pend_data <= disp_data;
                pend_dp   <= dp_mask;
                pend_en   <= digit_en;
            end
            if (frame_end) begin
                pending_valid <= 1'b0;
            end else if (disp_load) begin
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: expected scan words are queued as loads are driven
// and popped on each S_EN strobe.
module tb_seg7_scan_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int DIGIT_NUM = 7;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        Clk;
    logic        Rst;
    logic [27:0] disp_data;
    logic [6:0]  dp_mask;
    logic [6:0]  digit_en;
    logic        disp_load;
    logic [14:0] Data;
    logic        S_EN;

    int          cycle_no;
    int          last_strobe;
    int          n_assert;
    int          n_fail;
    int          push_digit;
    logic [14:0] exp_q [$];
    logic [27:0] m_data;
    logic [6:0]  m_dp;
    logic [6:0]  m_en;

    seg7_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .DIGIT_NUM (DIGIT_NUM)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .disp_data (disp_data),
        .dp_mask   (dp_mask),
        .digit_en  (digit_en),
        .disp_load (disp_load),
        .Data      (Data),
        .S_EN      (S_EN)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cycle_no = 0;
    always @(posedge Clk) cycle_no++;

    // Reference model of one scan word for digit d showing the given display state.
    function automatic logic [14:0] exp_word(int d, logic [27:0] data, logic [6:0] dp, logic [6:0] en);
        logic [6:0] sel;
        logic [7:0] seg;
        logic [3:0] nib;
        sel    = 7'h7F;
        sel[d] = 1'b0;
        nib    = data[4*d +: 4];
        seg    = {~dp[d], SEG_TBL[nib]};
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (data >> (4*d)) == 28'd0) seg[6:0] = 7'h7F;
`endif
        if (!en[d]) seg = 8'hFF;
        return {sel, seg};
    endfunction

    task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_one();
        exp_q.push_back(exp_word(push_digit, m_data, m_dp, m_en));
        push_digit = (push_digit == DIGIT_NUM - 1) ? 0 : push_digit + 1;
    endtask

    task automatic push_until_frame_end();
        while (push_digit != 0) push_one();
    endtask

    task automatic push_n(int n);
        repeat (n) push_one();
    endtask

    task automatic set_model(logic [27:0] data, logic [6:0] dp, logic [6:0] en);
        m_data = data;
        m_dp   = dp;
        m_en   = en;
    endtask

    // Drains the scoreboard; each strobe is checked for its word and its spacing.
    task automatic check_strobes();
        int waited;
        logic [14:0] exp;
        while (exp_q.size() > 0) begin
            waited = 0;
            do begin
                @(negedge Clk);
                waited++;
            end while (!S_EN && waited < 4 * SCAN_DIV);
            if (!S_EN) begin
                check_output("strobe_timeout", 32'(S_EN), 32'd1);
                exp_q.delete();
                return;
            end
            exp = exp_q.pop_front();
            check_output("scan_word", 32'(Data), 32'(exp));
            check_output("strobe_gap", 32'(cycle_no - last_strobe), 32'(SCAN_DIV));
            last_strobe = cycle_no;
        end
    endtask

    task automatic apply_stimulus(logic [27:0] data, logic [6:0] dp, logic [6:0] en);
        disp_data = data;
        dp_mask   = dp;
        digit_en  = en;
        disp_load = 1'b1;
        @(posedge Clk);
        #1 disp_load = 1'b0;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        last_strobe = 0;
        push_digit  = 1;
        Rst         = 1'b1;
        disp_data   = '0;
        dp_mask     = '0;
        digit_en    = '0;
        disp_load   = 1'b0;
        set_model(28'h0, 7'h00, 7'h00);

        repeat (2) @(negedge Clk);
        check_output("reset_data", 32'(Data), 32'h7FFF);
        check_output("reset_sen", 32'(S_EN), 32'd0);

        // Run past one strobe, then hit reset mid-count.
        Rst = 1'b0;
        repeat (6) @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        check_output("reset_mid_data", 32'(Data), 32'h7FFF);
        check_output("reset_mid_sen", 32'(S_EN), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        last_strobe = cycle_no;
        push_digit  = 1;
        push_n(DIGIT_NUM);
        check_strobes();

        // Decode: load mid-frame, new value starts at digit 0 of next frame.
        push_until_frame_end();
        apply_stimulus(28'h0123456, 7'h00, 7'h7F);
        set_model(28'h0123456, 7'h00, 7'h7F);
        push_n(DIGIT_NUM);
        check_strobes();

        // Load on the boundary tick bypasses straight to digit 0; also covers dp/enable.
        repeat (SCAN_DIV - 1) @(negedge Clk);
        apply_stimulus(28'h89ABCDE, 7'h04, 7'h7B);
        set_model(28'h89ABCDE, 7'h04, 7'h7B);
        push_n(DIGIT_NUM);
        check_strobes();

        // Tear-free: load after digit 2, rest of frame keeps the old value.
        push_n(3);
        check_strobes();
        push_until_frame_end();
        apply_stimulus(28'hFEDCBA9, 7'h7F, 7'h7F);
        set_model(28'hFEDCBA9, 7'h7F, 7'h7F);
        push_n(DIGIT_NUM);
        check_strobes();

        // Back-to-back loads within one frame: only the second is ever shown.
        push_n(2);
        check_strobes();
        push_until_frame_end();
        apply_stimulus(28'h1111111, 7'h00, 7'h7F);
        apply_stimulus(28'h2345678, 7'h55, 7'h7F);
        set_model(28'h2345678, 7'h55, 7'h7F);
        push_n(2 * DIGIT_NUM);
        check_strobes();

        // Zero-heavy values exercise leading-zero handling in either build.
        push_n(1);
        check_strobes();
        push_until_frame_end();
        apply_stimulus(28'h0000305, 7'h00, 7'h7F);
        set_model(28'h0000305, 7'h00, 7'h7F);
        push_n(DIGIT_NUM);
        check_strobes();
        push_n(1);
        check_strobes();
        push_until_frame_end();
        apply_stimulus(28'h0000000, 7'h00, 7'h7F);
        set_model(28'h0000000, 7'h00, 7'h7F);
        push_n(DIGIT_NUM);
        check_strobes();

        // Reset while a strobe is high clears everything, including shadow.
        #2 Rst = 1'b1;
        #1;
        check_output("reset_op_data", 32'(Data), 32'h7FFF);
        check_output("reset_op_sen", 32'(S_EN), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        last_strobe = cycle_no;
        set_model(28'h0, 7'h00, 7'h00);
        push_digit = 1;
        push_n(DIGIT_NUM);
        check_strobes();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
